// File: rtl/alu8_cmd_driver.sv
`default_nettype none
// ============================================================================
//  Module   : alu8_cmd_driver
//  Purpose  : Initiator-side controller for an 8-bit combinational ALU.
//             Commands arrive on a valid/ready stream and are buffered in a
//             circular FIFO. Each command is popped, driven to the ALU from
//             registers for one cycle, and the ALU output is captured and
//             returned on a valid/ready result stream. A running accumulator
//             holds the last result so chained commands can use it as the
//             left operand.
//  Ports    : clk, rst             - clock, asynchronous active-high reset
//             cmd_*_i / cmd_ready_o - command stream (op, acc flag, a, b)
//             acc_clr_i             - synchronous accumulator clear
//             alu_*_o / alu_result_i - registered ALU drive, ALU result
//             res_*                 - result stream (data, zero flag)
//             acc_o, busy_o         - accumulator value, activity status
//  Revision : 1.0 - initial release
// ============================================================================
module alu8_cmd_driver #(
    parameter int DEPTH = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       cmd_valid_i,
    output logic       cmd_ready_o,
    input  logic [1:0] cmd_op_i,
    input  logic       cmd_acc_i,
    input  logic [7:0] cmd_a_i,
    input  logic [7:0] cmd_b_i,
    input  logic       acc_clr_i,
    output logic [7:0] alu_left_o,
    output logic [7:0] alu_right_o,
    output logic [1:0] alu_mode_o,
    input  logic [7:0] alu_result_i,
    output logic       res_valid_o,
    input  logic       res_ready_i,
    output logic [7:0] res_data_o,
    output logic       res_zero_o,
    output logic [7:0] acc_o,
    output logic       busy_o
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [AW:0]   C_FULL    = DEPTH[AW:0];
    localparam logic [AW:0]   C_CNT_ONE = 1;
    localparam logic [AW-1:0] C_PTR_ONE = 1;

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_DRIVE = 2'd1;
    localparam logic [1:0] S_RESP  = 2'd2;

    // FIFO entry layout: {op[1:0], acc_flag, a[7:0], b[7:0]}
    logic [18:0]   fifo_mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q;
    logic [AW-1:0] rd_ptr_q;
    logic [AW:0]   count_q;

    logic [1:0] state_q;
    logic [1:0] state_d;
    logic [7:0] alu_left_q;
    logic [7:0] alu_right_q;
    logic [1:0] alu_mode_q;
    logic       res_valid_q;
    logic [7:0] res_data_q;
    logic       res_zero_q;
    logic [7:0] acc_q;

    logic        w_full;
    logic        w_empty;
    logic        w_push;
    logic        w_pop;
    logic [18:0] w_head;

    assign w_full  = (count_q == C_FULL);
    assign w_empty = (count_q == '0);
    assign w_push  = cmd_valid_i && !w_full;
    assign w_head  = fifo_mem_q[rd_ptr_q];

    // A pop only happens from IDLE or on the result handshake, so the
    // accumulator has always absorbed the previous result before the next
    // command reads it.
    always_comb begin
        state_d = state_q;
        w_pop   = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (!w_empty) begin
                    w_pop   = 1'b1;
                    state_d = S_DRIVE;
                end
            end
            S_DRIVE: begin
                state_d = S_RESP;
            end
            S_RESP: begin
                if (res_ready_i) begin
                    if (!w_empty) begin
                        w_pop   = 1'b1;
                        state_d = S_DRIVE;
                    end else begin
                        state_d = S_IDLE;
                    end
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Storage needs no reset: occupancy is tracked by the pointers/count.
    always_ff @(posedge clk) begin
        if (w_push) begin
            fifo_mem_q[wr_ptr_q] <= {cmd_op_i, cmd_acc_i, cmd_a_i, cmd_b_i};
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_IDLE;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            alu_left_q  <= 8'h00;
            alu_right_q <= 8'h00;
            alu_mode_q  <= 2'b00;
            res_valid_q <= 1'b0;
            res_data_q  <= 8'h00;
            res_zero_q  <= 1'b0;
            acc_q       <= 8'h00;
        end else begin
            state_q <= state_d;

            if (w_push) begin
                wr_ptr_q <= wr_ptr_q + C_PTR_ONE;
            end
            if (w_pop) begin
                rd_ptr_q <= rd_ptr_q + C_PTR_ONE;
            end
            case ({w_push, w_pop})
                2'b10:   count_q <= count_q + C_CNT_ONE;
                2'b01:   count_q <= count_q - C_CNT_ONE;
                default: count_q <= count_q;
            endcase

            if (w_pop) begin
                alu_mode_q  <= w_head[18:17];
                alu_right_q <= w_head[7:0];
                alu_left_q  <= w_head[16] ? acc_q : w_head[15:8];
            end

            if (state_q == S_DRIVE) begin
                res_data_q  <= alu_result_i;
                res_zero_q  <= (alu_result_i == 8'h00);
                res_valid_q <= 1'b1;
            end else if ((state_q == S_RESP) && res_ready_i) begin
                res_valid_q <= 1'b0;
            end

            // Clear has priority over the capture for the accumulator only.
            if (acc_clr_i) begin
                acc_q <= 8'h00;
            end else if (state_q == S_DRIVE) begin
                acc_q <= alu_result_i;
            end
        end
    end

    assign cmd_ready_o = !w_full;
    assign alu_left_o  = alu_left_q;
    assign alu_right_o = alu_right_q;
    assign alu_mode_o  = alu_mode_q;
    assign res_valid_o = res_valid_q;
    assign res_data_o  = res_data_q;
    assign res_zero_o  = res_zero_q;
    assign acc_o       = acc_q;
    assign busy_o      = (state_q != S_IDLE) || !w_empty;

endmodule
`default_nettype wire

// File: tb/tb_alu8_cmd_driver.sv
`default_nettype none
// ============================================================================
//  Module   : tb_alu8_cmd_driver
//  Purpose  : Self-checking bench for alu8_cmd_driver with an attached
//             behavioural 8-bit ALU and a queue-based reference model.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_alu8_cmd_driver;

    localparam int DEPTH = 4;

    typedef struct packed {
        logic [1:0] op;
        logic       accf;
        logic [7:0] a;
        logic [7:0] b;
    } cmd_t;

    logic       clk = 1'b0;
    logic       rst;
    logic       cmd_valid;
    logic       cmd_ready;
    logic [1:0] cmd_op;
    logic       cmd_acc;
    logic [7:0] cmd_a;
    logic [7:0] cmd_b;
    logic       acc_clr;
    logic [7:0] alu_left;
    logic [7:0] alu_right;
    logic [1:0] alu_mode;
    logic [7:0] alu_result;
    logic       res_valid;
    logic       res_ready;
    logic [7:0] res_data;
    logic       res_zero;
    logic [7:0] acc;
    logic       busy;

    int   n_chk  = 0;
    int   n_fail = 0;
    int   cyc    = 0;
    logic [7:0] m_acc = 8'h00;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [7:0] alu_fn(input logic [1:0] m, input logic [7:0] l, input logic [7:0] r);
        case (m)
            2'd0:    return 8'((int'(l) + int'(r)) % 256);
            2'd1:    return 8'((int'(l) - int'(r) + 256) % 256);
            2'd2:    return l & r;
            default: return l | r;
        endcase
    endfunction

    assign alu_result = alu_fn(alu_mode, alu_left, alu_right);

    // Reference: result of the next completed command, in push order.
    function automatic logic [7:0] model_next(input cmd_t c);
        logic [7:0] l;
        l     = c.accf ? m_acc : c.a;
        m_acc = alu_fn(c.op, l, c.b);
        return m_acc;
    endfunction

    alu8_cmd_driver #(.DEPTH(DEPTH)) dut (
        .clk          (clk),
        .rst          (rst),
        .cmd_valid_i  (cmd_valid),
        .cmd_ready_o  (cmd_ready),
        .cmd_op_i     (cmd_op),
        .cmd_acc_i    (cmd_acc),
        .cmd_a_i      (cmd_a),
        .cmd_b_i      (cmd_b),
        .acc_clr_i    (acc_clr),
        .alu_left_o   (alu_left),
        .alu_right_o  (alu_right),
        .alu_mode_o   (alu_mode),
        .alu_result_i (alu_result),
        .res_valid_o  (res_valid),
        .res_ready_i  (res_ready),
        .res_data_o   (res_data),
        .res_zero_o   (res_zero),
        .acc_o        (acc),
        .busy_o       (busy)
    );

    function automatic cmd_t rand_cmd();
        cmd_t c;
        c.op   = 2'($urandom_range(0, 3));
        c.accf = 1'($urandom_range(0, 1));
        c.a    = 8'($urandom);
        c.b    = 8'($urandom);
        return c;
    endfunction

    // Offer one command; returns after the accepting edge (+1).
    task automatic push_cmd(input cmd_t c, output bit ok);
        int n;
        n = 0;
        @(negedge clk);
        cmd_valid = 1'b1;
        cmd_op    = c.op;
        cmd_acc   = c.accf;
        cmd_a     = c.a;
        cmd_b     = c.b;
        while (!cmd_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        ok = cmd_ready;
        @(posedge clk);
        #1 cmd_valid = 1'b0;
    endtask

    // Wait for a result, sample it, then complete one handshake.
    task automatic get_result(output logic [7:0] d, output logic z, output logic [7:0] a, output bit ok);
        int n;
        n  = 0;
        ok = 1'b0;
        d  = 8'h00;
        z  = 1'b0;
        a  = 8'h00;
        @(negedge clk);
        while (!res_valid && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (res_valid) begin
            ok        = 1'b1;
            d         = res_data;
            z         = res_zero;
            a         = acc;
            res_ready = 1'b1;
            @(negedge clk);
            res_ready = 1'b0;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        n_chk++; if (alu_left !== 8'h00) begin n_fail++; $display("FAIL reset_alu_left got=%h exp=00", alu_left); end
        n_chk++; if (alu_right !== 8'h00) begin n_fail++; $display("FAIL reset_alu_right got=%h exp=00", alu_right); end
        n_chk++; if (alu_mode !== 2'b00) begin n_fail++; $display("FAIL reset_alu_mode got=%h exp=0", alu_mode); end
        n_chk++; if ({res_valid, res_zero, busy, cmd_ready} !== 4'b0001) begin n_fail++; $display("FAIL reset_flags got=%b exp=0001", {res_valid, res_zero, busy, cmd_ready}); end
        n_chk++; if ({res_data, acc} !== 16'h0000) begin n_fail++; $display("FAIL reset_data_acc got=%h exp=0000", {res_data, acc}); end
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_single_add();
        cmd_t c;
        bit   ok;
        logic [7:0] e;
        c = '{op: 2'd0, accf: 1'b0, a: 8'h3C, b: 8'h05};
        push_cmd(c, ok);
        n_chk++; if (!ok) begin n_fail++; $display("FAIL add_accept got=0 exp=1"); end
        @(negedge clk);
        n_chk++; if (busy !== 1'b1) begin n_fail++; $display("FAIL add_busy got=%b exp=1", busy); end
        @(negedge clk);
        n_chk++; if ({alu_mode, alu_left, alu_right} !== {2'd0, 8'h3C, 8'h05}) begin n_fail++; $display("FAIL add_alu_drive got=%h/%h/%h exp=0/3c/05", alu_mode, alu_left, alu_right); end
        n_chk++; if (res_valid !== 1'b0) begin n_fail++; $display("FAIL add_early_valid got=%b exp=0", res_valid); end
        @(negedge clk);
        e = model_next(c);
        n_chk++; if ({res_valid, res_data, res_zero, acc} !== {1'b1, e, 1'b0, e} || e !== 8'h41) begin n_fail++; $display("FAIL add_result got=v%b d%h z%b acc%h exp=v1 d41 z0 acc41", res_valid, res_data, res_zero, acc); end
        // Result must hold while the consumer stalls.
        repeat (3) @(negedge clk);
        n_chk++; if ({res_valid, res_data} !== {1'b1, 8'h41}) begin n_fail++; $display("FAIL add_stable got=v%b d%h exp=v1 d41", res_valid, res_data); end
        res_ready = 1'b1;
        @(negedge clk);
        res_ready = 1'b0;
        n_chk++; if (res_valid !== 1'b0) begin n_fail++; $display("FAIL add_drop got=%b exp=0", res_valid); end
    endtask

    task automatic test_chain();
        cmd_t c[3];
        logic [7:0] exp_v[3];
        logic [7:0] d, a, e;
        logic z;
        bit ok;
        c[0] = '{op: 2'd0, accf: 1'b0, a: 8'hFF, b: 8'h02};
        c[1] = '{op: 2'd1, accf: 1'b1, a: 8'h77, b: 8'h02};
        c[2] = '{op: 2'd1, accf: 1'b1, a: 8'h55, b: 8'h01};
        exp_v = '{8'h01, 8'hFF, 8'hFE};
        for (int i = 0; i < 3; i++) push_cmd(c[i], ok);
        for (int i = 0; i < 3; i++) begin
            get_result(d, z, a, ok);
            e = model_next(c[i]);
            n_chk++; if (!ok || d !== exp_v[i] || d !== e) begin n_fail++; $display("FAIL chain_%0d got=%h ok=%b exp=%h", i, d, ok, exp_v[i]); end
        end
        n_chk++; if (acc !== 8'hFE) begin n_fail++; $display("FAIL chain_acc got=%h exp=fe", acc); end
    endtask

    task automatic test_logic();
        cmd_t c0, c1;
        logic [7:0] d, a, e;
        logic z;
        bit ok;
        c0 = '{op: 2'd2, accf: 1'b0, a: 8'hF0, b: 8'h0F};
        c1 = '{op: 2'd3, accf: 1'b0, a: 8'hF0, b: 8'h0F};
        push_cmd(c0, ok);
        push_cmd(c1, ok);
        get_result(d, z, a, ok);
        e = model_next(c0);
        n_chk++; if (!ok || {d, z} !== {8'h00, 1'b1} || d !== e) begin n_fail++; $display("FAIL logic_and got=%h z%b exp=00 z1", d, z); end
        get_result(d, z, a, ok);
        e = model_next(c1);
        n_chk++; if (!ok || {d, z} !== {8'hFF, 1'b0} || d !== e) begin n_fail++; $display("FAIL logic_or got=%h z%b exp=ff z0", d, z); end
    endtask

    task automatic test_backpressure();
        cmd_t q[$];
        cmd_t c;
        int   accepted, got, n;
        int   t[5];
        logic [7:0] e;
        accepted = 0;
        got      = 0;
        res_ready = 1'b0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            c = rand_cmd();
            cmd_valid = 1'b1;
            cmd_op    = c.op;
            cmd_acc   = c.accf;
            cmd_a     = c.a;
            cmd_b     = c.b;
            if (cmd_ready) begin
                q.push_back(c);
                accepted++;
            end
        end
        @(negedge clk);
        cmd_valid = 1'b0;
        n_chk++; if (accepted != DEPTH + 1) begin n_fail++; $display("FAIL bp_accepted got=%0d exp=%0d", accepted, DEPTH + 1); end
        n_chk++; if (cmd_ready !== 1'b0) begin n_fail++; $display("FAIL bp_ready_low got=%b exp=0", cmd_ready); end
        res_ready = 1'b1;
        n = 0;
        while (got < 5 && n < 40) begin
            if (res_valid) begin
                e = (q.size() > 0) ? model_next(q.pop_front()) : 8'hXX;
                n_chk++; if ({res_data, res_zero} !== {e, (e == 8'h00)}) begin n_fail++; $display("FAIL bp_result_%0d got=%h z%b exp=%h", got, res_data, res_zero, e); end
                t[got] = cyc;
                got++;
            end
            @(negedge clk);
            n++;
        end
        res_ready = 1'b0;
        n_chk++; if (got != 5) begin n_fail++; $display("FAIL bp_count got=%0d exp=5", got); end
        for (int i = 1; i < 5; i++) begin
            if (i < got) begin
                n_chk++; if (t[i] - t[i-1] != 2) begin n_fail++; $display("FAIL bp_interval_%0d got=%0d exp=2", i, t[i] - t[i-1]); end
            end
        end
    endtask

    task automatic test_clear_collision();
        cmd_t c;
        bit ok;
        c = '{op: 2'd0, accf: 1'b0, a: 8'h10, b: 8'h20};
        push_cmd(c, ok);
        @(negedge clk);
        @(negedge clk);
        acc_clr = 1'b1;
        @(negedge clk);
        acc_clr = 1'b0;
        n_chk++; if ({res_valid, res_data, res_zero, acc} !== {1'b1, 8'h30, 1'b0, 8'h00}) begin n_fail++; $display("FAIL clr_collision got=v%b d%h z%b acc%h exp=v1 d30 z0 acc00", res_valid, res_data, res_zero, acc); end
        m_acc = 8'h00;
        res_ready = 1'b1;
        @(negedge clk);
        res_ready = 1'b0;
    endtask

    task automatic test_random();
        cmd_t q[$];
        cmd_t c;
        int   k;
        logic [7:0] d, a, e;
        logic z;
        bit ok;
        for (int r = 0; r < 6; r++) begin
            k = $urandom_range(1, 4);
            for (int i = 0; i < k; i++) begin
                c = rand_cmd();
                push_cmd(c, ok);
                if (ok) q.push_back(c);
            end
            for (int i = 0; i < k; i++) begin
                get_result(d, z, a, ok);
                e = (q.size() > 0) ? model_next(q.pop_front()) : 8'hXX;
                n_chk++; if (!ok || {d, z, a} !== {e, (e == 8'h00), e}) begin n_fail++; $display("FAIL rand_r%0d_%0d got=%h z%b acc%h exp=%h", r, i, d, z, a, e); end
            end
        end
    endtask

    task automatic test_reset_mid();
        cmd_t c;
        bit ok;
        int n, stale;
        for (int i = 0; i < 4; i++) push_cmd(rand_cmd(), ok);
        n = 0;
        while (!res_valid && n < 20) begin
            @(negedge clk);
            n++;
        end
        n_chk++; if (res_valid !== 1'b1) begin n_fail++; $display("FAIL rmid_setup got=%b exp=1", res_valid); end
        @(negedge clk);
        rst = 1'b1;
        #1;
        n_chk++; if ({res_valid, busy, cmd_ready} !== 3'b001) begin n_fail++; $display("FAIL rmid_flags got=%b exp=001", {res_valid, busy, cmd_ready}); end
        n_chk++; if ({alu_mode, alu_left, alu_right, acc} !== 26'h0) begin n_fail++; $display("FAIL rmid_regs got=%h/%h/%h acc%h exp=0", alu_mode, alu_left, alu_right, acc); end
        @(negedge clk);
        rst = 1'b0;
        m_acc = 8'h00;
        res_ready = 1'b1;
        stale = 0;
        repeat (10) begin
            @(negedge clk);
            if (res_valid || busy) stale++;
        end
        res_ready = 1'b0;
        n_chk++; if (stale != 0) begin n_fail++; $display("FAIL rmid_stale got=%0d exp=0", stale); end
        c = '{op: 2'd0, accf: 1'b1, a: 8'h12, b: 8'h34};
        push_cmd(c, ok);
        @(negedge clk);
        @(negedge clk);
        n_chk++; if ({res_valid, alu_left, alu_right} !== {1'b0, 8'h00, 8'h34}) begin n_fail++; $display("FAIL rmid_drive got=v%b l%h r%h exp=v0 l00 r34", res_valid, alu_left, alu_right); end
        @(negedge clk);
        n_chk++; if ({res_valid, res_data} !== {1'b1, model_next(c)}) begin n_fail++; $display("FAIL rmid_new got=v%b d%h exp=v1 d34", res_valid, res_data); end
        res_ready = 1'b1;
        @(negedge clk);
        res_ready = 1'b0;
    endtask

    initial begin
        rst       = 1'b1;
        cmd_valid = 1'b0;
        cmd_op    = 2'd0;
        cmd_acc   = 1'b0;
        cmd_a     = 8'h00;
        cmd_b     = 8'h00;
        acc_clr   = 1'b0;
        res_ready = 1'b0;
        test_reset();
        test_single_add();
        test_chain();
        test_logic();
        test_backpressure();
        test_clear_collision();
        test_random();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/alu8_cmd_driver.md
# alu8_cmd_driver

Initiator-side controller for the 8-bit combinational ALU (add / sub / and / or on `left`, `right`, `mode`, result `ALUout`). It accepts operation commands over a valid/ready stream and buffers them in a small FIFO. For each command it drives registered operands and mode into the ALU, captures the ALU result and returns it on a valid/ready result stream. It also keeps a running 8-bit accumulator, so chained operations can use the previous result as the left operand.

## Interface
- `DEPTH`, 4: command FIFO entries; a power of two, at least 2.
- `clk` in 1: single clock; all state changes on its rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `cmd_valid` in 1: a command is offered.
- `cmd_ready` out 1: the FIFO can accept a command; equals !full.
- `cmd_op` in 2: operation. 0 = add, 1 = sub, 2 = and, 3 = or.
- `cmd_acc` in 1: 1 means the left operand is the accumulator value at pop time; 0 means the left operand is `cmd_a`.
- `cmd_a` in 8: left operand, used when `cmd_acc` = 0.
- `cmd_b` in 8: right operand.
- `acc_clr` in 1: synchronous clear of the accumulator.
- `alu_left` out 8: registered value driven to the ALU `left` input.
- `alu_right` out 8: registered value driven to the ALU `right` input.
- `alu_mode` out 2: registered value driven to the ALU `mode` input.
- `alu_result` in 8: the ALU `ALUout` value, which is combinational from the three outputs above.
- `res_valid` out 1: a result is held.
- `res_ready` in 1: the consumer accepts the result.
- `res_data` out 8: captured result.
- `res_zero` out 1: 1 when the captured result is 8'h00.
- `acc` out 8: accumulator value.
- `busy` out 1: 1 when the FSM is not in IDLE or the FIFO is non-empty.

## Operation
- **Push:** a command is pushed when `cmd_valid` && `cmd_ready` at a clock edge. While `rst` is high, pushes are ignored.
- **FIFO pointers:** the FIFO is circular. Read and write pointers wrap modulo `DEPTH`. A count (or an extra pointer bit) distinguishes full from empty.
- **FIFO boundary cases:**
  - Push and pop on the same edge with the FIFO not full: count is unchanged.
  - FIFO full: `cmd_ready` = 0, so a coincident pop does not admit a push in that cycle.
- **FSM state IDLE:**
  - If the FIFO is non-empty, pop the head entry and load `alu_mode` = op, `alu_right` = b, and `alu_left` = (acc_flag ? `acc` : a).
  - Then go to DRIVE.
- **FSM state DRIVE (exactly one cycle):** the ALU inputs are stable from registers. At the end of the cycle:
  - `res_data` <= `alu_result`
  - `res_zero` <= (`alu_result` == 0)
  - `acc` <= `alu_result`
  - `res_valid` <= 1
  - go to RESP
- **FSM state RESP:** hold `res_valid` until `res_ready` is sampled high. On that handshake edge:
  - `res_valid` <= 0.
  - If the FIFO is non-empty, pop and load the ALU registers in the same edge and go to DRIVE.
  - Otherwise go to IDLE.
- **Accumulator ordering:** commands with `cmd_acc` = 1 always see every previously completed result, because a pop never occurs before the prior capture.
- **Arithmetic:** all arithmetic is 8-bit modulo, as performed by the ALU. There is no carry or overflow output. `alu_left`, `alu_right` and `alu_mode` hold their last value in IDLE and RESP.
- **`acc_clr`:** sets `acc` to 0 at the next edge. If it coincides with the DRIVE capture edge, clear wins for `acc`, while `res_data` and `res_zero` still take the result.
- **Reset (asserted at any time, including mid-operation):** the FIFO is emptied, the FSM returns to IDLE, and every output takes its reset value immediately.

## Timing
- **Reset values:**
  - `alu_left`, `alu_right`, `res_data`, `acc`: 8'h00.
  - `alu_mode`: 2'b00.
  - `res_valid`, `res_zero`, `busy`: 0.
  - `cmd_ready`: 1 (FIFO empty).
- **Latency:** with the FIFO empty and the FSM in IDLE, a command accepted at edge k produces:
  - `alu_*` valid after edge k+1;
  - `res_valid` = 1 after edge k+2.
- **Throughput:** with `res_ready` held high, one result every 2 cycles (RESP → DRIVE → RESP).
- **Capacity with results stalled:** with `res_ready` low, at most `DEPTH` + 1 commands are accepted (one in RESP, `DEPTH` queued). `cmd_ready` falls on the edge that fills the FIFO.
- **Stability:** `res_data` and `res_zero` stay stable while `res_valid` = 1 and `res_ready` = 0.

## Test plan
- **Single add:** reset, then push op=0, a=8'h3C, b=8'h05, acc=0 at edge k. Required:
  - `alu_mode`=0, `alu_left`=8'h3C, `alu_right`=8'h05 after k+1.
  - `res_valid`=1, `res_data`=8'h41, `res_zero`=0, `acc`=8'h41 after k+2.
- **Chained accumulator with wrap:** push (op0, a=8'hFF, b=8'h02), then (op1, acc=1, b=8'h02), then (op1, acc=1, b=8'h01). Required results in order: 8'h01, 8'hFF, 8'hFE; final `acc`=8'hFE.
- **Logic ops and zero flag:** push op=2, a=8'hF0, b=8'h0F, then op=3 with the same operands. Required:
  - First result 8'h00 with `res_zero`=1.
  - Second result 8'hFF with `res_zero`=0.
- **Backpressure:** hold `res_ready`=0 and offer 8 back-to-back commands. Required:
  - Exactly 5 accepted (`DEPTH`=4); `cmd_ready`=0 afterwards.
  - Then raise `res_ready`: 5 results arrive in push order, one every 2 cycles.
- **Clear collision:** assert `acc_clr` on the DRIVE capture edge of op0, a=8'h10, b=8'h20. Required: `res_data`=8'h30 and `acc`=8'h00.
- **Reset mid-operation:** assert `rst` in RESP with 3 commands queued. Required:
  - Immediately `res_valid`=0, `busy`=0, all `alu_*`=0, `cmd_ready`=1.
  - After release, no stale result appears.
  - A new command completes with the normal 2-cycle latency.
